// File: rtl/comma_aligner.sv
// K28.5 comma aligner: hunts for the comma in either disparity on a 1-bit serial line
// and, once locked, delivers one aligned 10-bit symbol every 10 enabled cycles.
//   state  | meaning
//   HUNT   | no alignment; any comma sets the boundary
//   VERIFY | boundary set; counting aligned commas toward lock
//   LOCKED | symbols emitted; off-boundary commas counted toward loss
module comma_aligner #(
  parameter int         LOCK_COMMAS = 2,
  parameter int         LOSS_COUNT  = 3,
  parameter logic [9:0] COMMA_NEG   = 10'h0FA,
  parameter logic [9:0] COMMA_POS   = 10'h305
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enb,
  input  logic       serialIn,
  output logic [9:0] symbol,
  output logic       symbolValid,
  output logic       isComma,
  output logic       locked,
  output logic       alignErr
);

  localparam logic [1:0] HUNT   = 2'd0;
  localparam logic [1:0] VERIFY = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  localparam int CW = $clog2(LOCK_COMMAS + 1);
  localparam int EW = $clog2(LOSS_COUNT + 1);
  localparam logic [CW-1:0] COMMA_LAST    = CW'(LOCK_COMMAS - 1);
  localparam logic [EW-1:0] ERR_LAST      = EW'(LOSS_COUNT - 1);
  localparam logic [1:0]    REALIGN_STATE = (LOCK_COMMAS == 1) ? LOCKED : VERIFY;

  logic [8:0]    sr;
  logic [9:0]    win;
  logic          match;
  logic          boundary;
  logic [3:0]    bitCnt;
  logic [1:0]    state;
  logic [CW-1:0] commaCnt;
  logic [EW-1:0] errCnt;

  assign win      = {sr, serialIn};
  assign match    = (win == COMMA_NEG) || (win == COMMA_POS);
  assign boundary = (bitCnt == 4'd9);
  assign locked   = (state == LOCKED);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr          <= '0;
      bitCnt      <= '0;
      commaCnt    <= '0;
      errCnt      <= '0;
      state       <= HUNT;
      symbol      <= '0;
      symbolValid <= 1'b0;
      isComma     <= 1'b0;
      alignErr    <= 1'b0;
    end else begin
      symbolValid <= 1'b0;
      isComma     <= 1'b0;
      alignErr    <= 1'b0;
      if (enb) begin
        sr     <= win[8:0];
        bitCnt <= boundary ? 4'd0 : bitCnt + 4'd1;
        case (state)
          HUNT: begin
            if (match) begin
              bitCnt   <= 4'd0;
              commaCnt <= CW'(1);
              errCnt   <= '0;
              if (LOCK_COMMAS == 1) begin
                state       <= LOCKED;
                symbol      <= win;
                symbolValid <= 1'b1;
                isComma     <= 1'b1;
              end else begin
                state <= VERIFY;
              end
            end
          end
          VERIFY: begin
            if (match) begin
              if (boundary) begin
                commaCnt <= commaCnt + CW'(1);
                if (commaCnt == COMMA_LAST) begin
                  state       <= LOCKED;
                  symbol      <= win;
                  symbolValid <= 1'b1;
                  isComma     <= 1'b1;
                  errCnt      <= '0;
                end
              end else begin
                // comma off the current boundary restarts verification on it
                bitCnt   <= 4'd0;
                commaCnt <= CW'(1);
              end
            end
          end
          LOCKED: begin
            if (boundary) begin
              symbol      <= win;
              symbolValid <= 1'b1;
              isComma     <= match;
              if (match) errCnt <= '0;
            end else if (match) begin
              alignErr <= 1'b1;
              if (errCnt == ERR_LAST) begin
                state    <= REALIGN_STATE;
                bitCnt   <= 4'd0;
                commaCnt <= CW'(1);
                errCnt   <= '0;
              end else begin
                errCnt <= errCnt + EW'(1);
              end
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule
